// File: rtl/spw_host_pkg.sv
// Shared SpaceWire host-side definitions: control-char codes, reader FSM states
// and the per-packet status record.
package spw_host_pkg;

  localparam logic [8:0] EOP_CHAR   = 9'h100;
  localparam logic [8:0] EEP_CHAR   = 9'h101;
  localparam int         STAT_LEN_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_INPKT   = 2'd1,
    ST_DISCARD = 2'd2
  } rd_state_e;

  typedef struct packed {
    logic [STAT_LEN_W-1:0] len;
    logic                  eep;
    logic                  trunc;
  } pkt_status_t;

  function automatic logic is_marker(input logic [8:0] c);
    return c[8];
  endfunction

  // Any control char other than EOP closes the packet as an error end.
  function automatic logic is_eep(input logic [8:0] c);
    return (c == EEP_CHAR) || (c[8] && (c != EOP_CHAR));
  endfunction

endpackage

// File: rtl/spw_rx_skid.sv
// Two-entry buffer behind the codec FIFO: absorbs the one-cycle read latency and
// tells the fetch logic whether another pop request still has a guaranteed slot.
module spw_rx_skid (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rd_i,
  input  logic [8:0] rx_data_i,
  input  logic       pop_i,
  output logic [8:0] head_o,
  output logic [1:0] count_o,
  output logic       room_o
);

  logic [8:0] ent0_q, ent0_d;
  logic [8:0] ent1_q, ent1_d;
  logic [1:0] count_q, count_d;
  logic       inflight_q;

  always_comb begin
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    count_d = count_q;
    if (pop_i && (count_q != 2'd0)) begin
      ent0_d  = ent1_q;
      count_d = count_q - 2'd1;
    end
    // A read issued last cycle returns its char now and always has a slot.
    if (inflight_q) begin
      if (count_d == 2'd0) ent0_d = rx_data_i;
      else                 ent1_d = rx_data_i;
      count_d = count_d + 2'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ent0_q     <= '0;
      ent1_q     <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
    end else begin
      ent0_q     <= ent0_d;
      ent1_q     <= ent1_d;
      count_q    <= count_d;
      inflight_q <= rd_i;
    end
  end

  assign head_o  = ent0_q;
  assign count_o = count_q;
  assign room_o  = ({1'b0, count_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop_i});

endmodule

// File: rtl/spw_rx_packet_reader.sv
// SpaceWire RX packet reader: pops N-Chars from the codec FIFO, splits packets at
// EOP/EEP and presents bytes on a valid/ready stream with a per-packet status pulse.
module spw_rx_packet_reader
  import spw_host_pkg::*;
#(
  parameter int MAX_LEN = 1024,
  parameter int LEN_W   = 11
) (
  input  logic             CLOCK,
  input  logic             RESETn,
  input  logic             ENABLE,
  input  logic             RX_EMPTY,
  input  logic [8:0]       RX_DATA,
  output logic             RD_DATA,
  output logic [7:0]       M_DATA,
  output logic             M_VALID,
  input  logic             M_READY,
  output logic             M_FIRST,
  output logic             M_LAST,
  output logic             PKT_DONE,
  output logic [LEN_W-1:0] PKT_LEN,
  output logic             PKT_EEP,
  output logic             PKT_TRUNC,
  output logic             BUSY,
  output logic [1:0]       DBG_STATE
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  rd_state_e        state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [7:0]       hold_data_q, hold_data_d;
  logic             hold_first_q, hold_first_d;
  logic             m_valid_q, m_first_q, m_last_q;
  logic [7:0]       m_data_q;
  logic             pend_q, done_q, run_q;
  pkt_status_t      pend_stat_q, pend_stat_d, stat_q;

  logic [8:0] head;
  logic [1:0] skid_count;
  logic       room, head_mark, head_eep, out_free, proc, done_now;
  logic       emit, emit_last, pend_set;

  spw_rx_skid u_skid (
    .clk_i     (CLOCK),
    .rst_ni    (RESETn),
    .rd_i      (RD_DATA),
    .rx_data_i (RX_DATA),
    .pop_i     (proc),
    .head_o    (head),
    .count_o   (skid_count),
    .room_o    (room)
  );

  assign RD_DATA   = run_q && ENABLE && !RX_EMPTY && room;
  assign head_mark = is_marker(head);
  assign head_eep  = is_eep(head);

  // Stream: a beat transfers when M_VALID && M_READY; while stalled the beat is held unchanged.
  assign out_free = !m_valid_q || M_READY;
  // A closed packet blocks new chars until its status has been reported.
  assign proc     = (skid_count != 2'd0) && !pend_q && ((state_q != ST_INPKT) || out_free);
  assign done_now = pend_q && out_free;

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    hold_data_d  = hold_data_q;
    hold_first_d = hold_first_q;
    pend_stat_d  = pend_stat_q;
    emit         = 1'b0;
    emit_last    = 1'b0;
    pend_set     = 1'b0;
    if (proc) begin
      case (state_q)
        ST_IDLE: begin
          if (head_mark) begin
            pend_set    = 1'b1;
            pend_stat_d = '{len: '0, eep: head_eep, trunc: 1'b0};
          end else begin
            state_d      = ST_INPKT;
            len_d        = LEN_W'(1);
            hold_data_d  = head[7:0];
            hold_first_d = 1'b1;
          end
        end
        ST_INPKT: begin
          emit = 1'b1;
          if (head_mark) begin
            emit_last   = 1'b1;
            pend_set    = 1'b1;
            pend_stat_d = '{len: STAT_LEN_W'(len_q), eep: head_eep, trunc: 1'b0};
            state_d     = ST_IDLE;
          end else if (len_q == LEN_MAX) begin
            emit_last = 1'b1;
            state_d   = ST_DISCARD;
          end else begin
            len_d        = len_q + LEN_W'(1);
            hold_data_d  = head[7:0];
            hold_first_d = 1'b0;
          end
        end
        ST_DISCARD: begin
          if (head_mark) begin
            pend_set    = 1'b1;
            pend_stat_d = '{len: STAT_LEN_W'(LEN_MAX), eep: head_eep, trunc: 1'b1};
            state_d     = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK or negedge RESETn) begin
    if (!RESETn) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      hold_data_q  <= '0;
      hold_first_q <= 1'b0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_first_q    <= 1'b0;
      m_last_q     <= 1'b0;
      pend_q       <= 1'b0;
      pend_stat_q  <= '0;
      stat_q       <= '0;
      done_q       <= 1'b0;
      run_q        <= 1'b0;
    end else begin
      run_q        <= 1'b1;
      state_q      <= state_d;
      len_q        <= len_d;
      hold_data_q  <= hold_data_d;
      hold_first_q <= hold_first_d;
      pend_stat_q  <= pend_stat_d;
      done_q       <= done_now;
      if (emit) begin
        m_valid_q <= 1'b1;
        m_data_q  <= hold_data_q;
        m_first_q <= hold_first_q;
        m_last_q  <= emit_last;
      end else if (M_READY) begin
        m_valid_q <= 1'b0;
      end
      if (done_now) begin
        pend_q <= 1'b0;
        stat_q <= pend_stat_q;
      end else if (pend_set) begin
        pend_q <= 1'b1;
      end
    end
  end

  logic unused_len_bits;
  assign unused_len_bits = &{1'b0, stat_q.len[STAT_LEN_W-1:LEN_W]};

  assign M_VALID   = m_valid_q;
  assign M_DATA    = m_data_q;
  assign M_FIRST   = m_first_q;
  assign M_LAST    = m_last_q;
  assign PKT_DONE  = done_q;
  assign PKT_LEN   = stat_q.len[LEN_W-1:0];
  assign PKT_EEP   = stat_q.eep;
  assign PKT_TRUNC = stat_q.trunc;
  assign BUSY      = (state_q != ST_IDLE);
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_spw_rx_packet_reader.sv
// Bench for spw_rx_packet_reader: a default-size reader and a MAX_LEN=4 reader, each
// fed by a codec FIFO model, checked against expected beat and status queues.
module tb_spw_rx_packet_reader;
  import spw_host_pkg::*;

  localparam int LEN_A = 11;
  localparam int MAX_B = 4;
  localparam int LEN_B = 3;

  // ---------------- clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // ---------------- DUT A (MAX_LEN = 1024)
  logic             en_a = 1'b0, empty_a = 1'b1, ready_a = 1'b0;
  logic [8:0]       rxd_a = '0;
  logic             rd_a, valid_a, first_a, last_a, done_a, eep_a, trunc_a, busy_a;
  logic [7:0]       data_a;
  logic [LEN_A-1:0] len_a;
  logic [1:0]       dbg_a;

  spw_rx_packet_reader dut_a (
    .CLOCK(clk), .RESETn(rst_n), .ENABLE(en_a), .RX_EMPTY(empty_a), .RX_DATA(rxd_a),
    .RD_DATA(rd_a), .M_DATA(data_a), .M_VALID(valid_a), .M_READY(ready_a),
    .M_FIRST(first_a), .M_LAST(last_a), .PKT_DONE(done_a), .PKT_LEN(len_a),
    .PKT_EEP(eep_a), .PKT_TRUNC(trunc_a), .BUSY(busy_a), .DBG_STATE(dbg_a)
  );

  // ---------------- DUT B (MAX_LEN = 4)
  logic             en_b = 1'b0, empty_b = 1'b1, ready_b = 1'b0;
  logic [8:0]       rxd_b = '0;
  logic             rd_b, valid_b, first_b, last_b, done_b, eep_b, trunc_b, busy_b;
  logic [7:0]       data_b;
  logic [LEN_B-1:0] len_b;
  logic [1:0]       dbg_b;

  spw_rx_packet_reader #(.MAX_LEN(MAX_B), .LEN_W(LEN_B)) dut_b (
    .CLOCK(clk), .RESETn(rst_n), .ENABLE(en_b), .RX_EMPTY(empty_b), .RX_DATA(rxd_b),
    .RD_DATA(rd_b), .M_DATA(data_b), .M_VALID(valid_b), .M_READY(ready_b),
    .M_FIRST(first_b), .M_LAST(last_b), .PKT_DONE(done_b), .PKT_LEN(len_b),
    .PKT_EEP(eep_b), .PKT_TRUNC(trunc_b), .BUSY(busy_b), .DBG_STATE(dbg_b)
  );

  // ---------------- scoreboard state
  int n_checks = 0;
  int n_errors = 0;
  logic [8:0]  fifo_a[$], fifo_b[$];
  logic [9:0]  exp_beat_a[$], exp_beat_b[$];   // {first, last, data}
  logic [31:0] exp_done_a[$], exp_done_b[$];   // {beats so far, 3'b0, len, eep, trunc}
  int beat_cyc_a[$];
  int beats_a = 0, beats_b = 0, pushed_a = 0, pushed_b = 0;
  logic stall_a = 1'b0, stall_b = 1'b0;
  logic [10:0] prev_a = '0, prev_b = '0;
  bit rand_ready_a = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- codec FIFO models (data valid one cycle after the pop)
  always @(posedge clk) begin
    if (rd_a) begin
      check("rd_nonempty_a", 32'(empty_a), 32'd0);
      if (fifo_a.size() != 0) rxd_a <= fifo_a.pop_front();
    end
    empty_a <= (fifo_a.size() == 0);
  end

  always @(posedge clk) begin
    if (rd_b) begin
      check("rd_nonempty_b", 32'(empty_b), 32'd0);
      if (fifo_b.size() != 0) rxd_b <= fifo_b.pop_front();
    end
    empty_b <= (fifo_b.size() == 0);
  end

  // ---------------- output monitors
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_a = 1'b0;
    end else begin
      if (stall_a) check("stall_hold_a", 32'({valid_a, first_a, last_a, data_a}), 32'(prev_a));
      stall_a = valid_a && !ready_a;
      prev_a  = {valid_a, first_a, last_a, data_a};
      if (valid_a && ready_a) begin
        if (exp_beat_a.size() == 0) check("beat_extra_a", 32'({first_a, last_a, data_a}), 32'hffff_ffff);
        else check("beat_a", 32'({first_a, last_a, data_a}), 32'(exp_beat_a.pop_front()));
        beats_a++;
        beat_cyc_a.push_back(cyc);
      end
      if (done_a) begin
        if (exp_done_a.size() == 0) check("done_extra_a", 32'({len_a, eep_a, trunc_a}), 32'hffff_ffff);
        else check("done_a", {beats_a[15:0], 3'b000, len_a, eep_a, trunc_a}, exp_done_a.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_b = 1'b0;
    end else begin
      if (stall_b) check("stall_hold_b", 32'({valid_b, first_b, last_b, data_b}), 32'(prev_b));
      stall_b = valid_b && !ready_b;
      prev_b  = {valid_b, first_b, last_b, data_b};
      if (valid_b && ready_b) begin
        if (exp_beat_b.size() == 0) check("beat_extra_b", 32'({first_b, last_b, data_b}), 32'hffff_ffff);
        else check("beat_b", 32'({first_b, last_b, data_b}), 32'(exp_beat_b.pop_front()));
        beats_b++;
      end
      if (done_b) begin
        if (exp_done_b.size() == 0) check("done_extra_b", 32'({len_b, eep_b, trunc_b}), 32'hffff_ffff);
        else check("done_b", {beats_b[15:0], 3'b000, 8'h00, len_b, eep_b, trunc_b}, exp_done_b.pop_front());
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (rand_ready_a) ready_a = 1'($urandom_range(0, 1));
  end

  // ---------------- driver tasks
  task automatic send_pkt_a(input int n, input logic [7:0] start, input bit rnd, input logic [8:0] mark);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = rnd ? 8'($urandom_range(0, 255)) : start + 8'(i);
      fifo_a.push_back({1'b0, b});
      exp_beat_a.push_back({(i == 0), (i == n - 1), b});
    end
    fifo_a.push_back(mark);
    pushed_a += n;
    exp_done_a.push_back({pushed_a[15:0], 3'b000, LEN_A'(n), (mark != EOP_CHAR), 1'b0});
  endtask

  task automatic send_pkt_b(input int n, input logic [7:0] start, input logic [8:0] mark);
    int k;
    k = (n < MAX_B) ? n : MAX_B;
    for (int i = 0; i < n; i++) begin
      fifo_b.push_back({1'b0, start + 8'(i)});
      if (i < k) exp_beat_b.push_back({(i == 0), (i == k - 1), start + 8'(i)});
    end
    fifo_b.push_back(mark);
    pushed_b += k;
    exp_done_b.push_back({pushed_b[15:0], 3'b000, 11'(k), (mark != EOP_CHAR), (n > MAX_B)});
  endtask

  task automatic wait_drain_a(input int budget);
    int c = 0;
    while ((exp_beat_a.size() != 0 || exp_done_a.size() != 0) && c < budget) begin
      @(posedge clk); c++;
    end
    repeat (2) @(posedge clk);
    #1;
    check("drain_a", 32'(exp_beat_a.size() + exp_done_a.size()), 32'd0);
  endtask

  task automatic wait_drain_b(input int budget);
    int c = 0;
    while ((exp_beat_b.size() != 0 || exp_done_b.size() != 0) && c < budget) begin
      @(posedge clk); c++;
    end
    repeat (2) @(posedge clk);
    #1;
    check("drain_b", 32'(exp_beat_b.size() + exp_done_b.size()), 32'd0);
  endtask

  task automatic wait_beats_a(input int target, input int budget);
    int c = 0;
    while (beats_a < target && c < budget) begin
      @(posedge clk); c++;
    end
    #1;
    check("beats_reached_a", 32'(beats_a >= target), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1);
  end

  // ---------------- main sequence
  initial begin
    int base;
    repeat (3) @(posedge clk);
    #1;
    check("reset_a", 32'({rd_a, valid_a, first_a, last_a, done_a, eep_a, trunc_a, busy_a, data_a, len_a}), 32'd0);
    check("reset_b", 32'({rd_b, valid_b, first_b, last_b, done_b, eep_b, trunc_b, busy_b, data_b, len_b}), 32'd0);
    rst_n = 1'b1; en_a = 1'b1; en_b = 1'b1; ready_a = 1'b1; ready_b = 1'b1;
    @(posedge clk); #1;

    // Basic packet: three beats back to back.
    base = beat_cyc_a.size();
    send_pkt_a(3, 8'h0A, 1'b0, EOP_CHAR);
    wait_drain_a(60);
    check("t1_gap01", 32'(beat_cyc_a[base + 1] - beat_cyc_a[base]), 32'd1);
    check("t1_gap12", 32'(beat_cyc_a[base + 2] - beat_cyc_a[base + 1]), 32'd1);

    // Empty packet, one-byte EEP packet, unknown control char treated as EEP.
    send_pkt_a(0, 8'h00, 1'b0, EOP_CHAR);
    send_pkt_a(1, 8'h55, 1'b0, EEP_CHAR);
    send_pkt_a(2, 8'h70, 1'b0, 9'h1FF);
    wait_drain_a(100);

    // Truncation on the MAX_LEN=4 reader, plus the exact-fit boundary.
    send_pkt_b(10, 8'h00, EOP_CHAR);
    wait_drain_b(100);
    check("t3_popped_all", 32'(fifo_b.size()), 32'd0);
    send_pkt_b(4, 8'h20, EEP_CHAR);
    send_pkt_b(5, 8'h40, EOP_CHAR);
    send_pkt_b(1, 8'h60, EOP_CHAR);
    wait_drain_b(200);
    check("t3_idle_b", 32'({busy_b, dbg_b}), 32'd0);

    // Random backpressure over a long packet.
    rand_ready_a = 1'b1;
    send_pkt_a(200, 8'h00, 1'b1, EOP_CHAR);
    send_pkt_a(3, 8'h90, 1'b1, EEP_CHAR);
    wait_drain_a(3000);
    rand_ready_a = 1'b0;
    ready_a = 1'b1;

    // Reset in the middle of a packet.
    send_pkt_a(10, 8'h10, 1'b0, EOP_CHAR);
    wait_beats_a(beats_a + 5, 100);
    check("rst_busy_before", 32'(busy_a), 32'd1);
    rst_n = 1'b0;
    fifo_a.delete();
    exp_beat_a.delete();
    exp_done_a.delete();
    repeat (2) @(posedge clk);
    #1;
    check("rst_mid_a", 32'({rd_a, valid_a, first_a, last_a, done_a, eep_a, trunc_a, busy_a, data_a, len_a}), 32'd0);
    pushed_a = beats_a;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_pkt_a(7, 8'hC0, 1'b0, EEP_CHAR);
    wait_drain_a(100);

    // ENABLE dropped mid-packet for 20 cycles.
    send_pkt_a(40, 8'h00, 1'b1, EOP_CHAR);
    wait_beats_a(beats_a + 10, 100);
    en_a = 1'b0;
    repeat (20) begin
      @(negedge clk);
      check("en_gap_rd", 32'(rd_a), 32'd0);
    end
    check("en_gap_busy", 32'(busy_a), 32'd1);
    check("en_gap_fifo_left", 32'(fifo_a.size() > 0), 32'd1);
    @(posedge clk); #1;
    en_a = 1'b1;
    wait_drain_a(300);
    check("final_idle_a", 32'({busy_a, dbg_a, valid_a}), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
